// File: rtl/vga_meas_text_buffer.sv
// Text-buffer engine for the voltmeter VGA overlay: snapshots BCD readings
// and redraws a ROWS x COLS char RAM; registered read port. Opt: VGA_TEXT_HOLD_EN.
module vga_meas_text_buffer #(
  parameter int CHANNELS = 13,
  parameter int DIGITS   = 4,
  parameter int COL_W    = 4,
  parameter int ROW_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*4*DIGITS-1:0] bcd_in,
  input  logic                         update,
`ifdef VGA_TEXT_HOLD_EN
  input  logic                         hold,
`endif
  input  logic [ROW_W+COL_W-1:0]       text_xy,
  output logic [6:0]                   char_code,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int AW    = ROW_W + COL_W;
  localparam int CELLS = 2**AW;
  localparam int RW    = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE, SNAP, WRITE, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CHANNELS*RW-1:0] snap_q, snap_d;
  logic                   pending_q, pending_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [6:0]             char_q, char_d;
  logic                   hold_q, hold_d;
  logic                   hold_now;
  logic [6:0]             wdata;
  logic [RW-1:0]          rd;
  int                     row, col, ch;
  logic [6:0]             mem [CELLS];

`ifdef VGA_TEXT_HOLD_EN
  assign hold_now = hold;
`else
  assign hold_now = 1'b0;
`endif

  function automatic logic [6:0] dig(input logic [3:0] n);
    return (n > 4'd9) ? 7'h3F : 7'h30 + {3'b000, n};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SNAP;
      snap_q    <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      char_q    <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      char_q    <= char_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if ((update || pending_q) && !hold_now)
          state_d = SNAP;
      SNAP:  state_d = WRITE;
      WRITE:
        if (addr_q == '1)
          state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_d    = snap_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: addr_d = '0;
      SNAP: begin
        snap_d    = bcd_in;
        hold_d    = hold_now;
        pending_d = update;
        addr_d    = '0;
      end
      WRITE: begin
        addr_d    = addr_q + AW'(1);
        pending_d = pending_q | update;
      end
      default: pending_d = pending_q | update;
    endcase
  end

  always_comb begin
    busy_d = (state_q == SNAP) || (state_q == WRITE);
    done_d = (state_q == DONE);
    char_d = mem[text_xy];
  end

  // Glyph for the cell currently being written
  always_comb begin
    row   = int'(addr_q[AW-1:COL_W]);
    col   = int'(addr_q[COL_W-1:0]);
    ch    = (row < CHANNELS) ? row : 0;
    rd    = snap_q[ch*RW +: RW];
    wdata = 7'h20;
    if (row < CHANNELS) begin
      unique case (1'b1)
        (col == 0): wdata = dig(4'(row / 10));
        (col == 1): wdata = dig(4'(row % 10));
        (col == 2): wdata = 7'h3A;
        (col == 4): wdata = dig(rd[RW-1 -: 4]);
        (col == 5): wdata = 7'h2E;
        (col >= 6 && col <= 4 + DIGITS):
          wdata = dig(rd[(DIGITS+4-col)*4 +: 4]);
        (col == 6 + DIGITS): wdata = 7'h56;
        (col == 7 + DIGITS && hold_q):
          wdata = 7'h48;
        default: wdata = 7'h20;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == WRITE)
      mem[addr_q] <= wdata;
  end

  assign char_code  = char_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_vga_meas_text_buffer.sv
// Directed self-checking bench for vga_meas_text_buffer.
// Cell contents checked through table-driven read vectors.
module tb_vga_meas_text_buffer;
  localparam int CH = 13;
  localparam int NB = CH * 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] bcd_in;
  logic          update;
  logic [7:0]    text_xy;
  logic [6:0]    char_code;
  logic          busy;
  logic          frame_done;
`ifdef VGA_TEXT_HOLD_EN
  logic          hold;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         row;
    int         col;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  vga_meas_text_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .update     (update),
`ifdef VGA_TEXT_HOLD_EN
    .hold       (hold),
`endif
    .text_xy    (text_xy),
    .char_code  (char_code),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  task automatic add_str(input int row, input int c0,
                         input string s);
    vec_t v;
    for (int i = 0; i < s.len(); i++) begin
      v.row = row;
      v.col = c0 + i;
      v.exp = 7'(s[i]);
      tbl.push_back(v);
    end
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      text_xy = 8'(v.row * 16 + v.col);
      @(posedge clk);
      #1;
      check($sformatf("%s r%0d c%0d", tag, v.row, v.col),
            int'(char_code), int'(v.exp));
    end
    tbl.delete();
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    bcd_in[k*16 +: 16] = v;
  endtask

  task automatic pulse_update();
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected frame_done",
               name);
    end
  endtask

  task automatic count_to_done(input string name);
    int n = 0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_done) break;
    end
    check(name, n, 258);
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    update  = 1'b0;
    bcd_in  = '0;
    text_xy = '0;
`ifdef VGA_TEXT_HOLD_EN
    hold    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst char_code", int'(char_code), 0);
    check("rst busy", int'(busy), 0);
    check("rst frame_done", int'(frame_done), 0);

    @(negedge clk);
    rst = 1'b0;
    count_to_done("boot latency");
    check("boot busy at done", int'(busy), 0);
    add_str(0, 0, "00: 0.000 V     ");
    add_str(12, 0, "12: 0.000 V     ");
    add_str(13, 0, "                ");
    add_str(15, 0, "                ");
    run_table("boot");

    set_ch(3, 16'h1234);
    pulse_update();
    n = 0;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk);
      #1;
      if (busy) n++;
      else if (n > 0) break;
    end
    check("busy length", n, 257);
    check("done at busy fall", int'(frame_done), 1);
    add_str(3, 0, "03: 1.234 V");
    run_table("ch3");

    set_ch(0, 16'h9A05);
    pulse_update();
    wait_done("ch0 pass");
    add_str(0, 4, "9.?05");
    run_table("ch0");

    pulse_update();
    repeat (10) @(posedge clk);
    pulse_update();
    repeat (40) @(posedge clk);
    pulse_update();
    repeat (100) @(posedge clk);
    pulse_update();
    n = 0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) n++;
    end
    check("collapsed passes", n, 2);
    check("idle busy", int'(busy), 0);

    set_ch(5, 16'h1111);
    pulse_update();
    repeat (20) @(posedge clk);
    set_ch(5, 16'h2222);
    wait_done("snap pass");
    add_str(5, 0, "05: 1.111 V");
    run_table("snap");
    pulse_update();
    wait_done("snap pass2");
    add_str(5, 4, "2.222");
    run_table("snap2");

    pulse_update();
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", int'(busy), 0);
    check("midrst char", int'(char_code), 0);
    check("midrst done", int'(frame_done), 0);
    @(negedge clk);
    rst = 1'b0;
    count_to_done("midrst latency");
    add_str(0, 0, "00: 9.?05 V ");
    add_str(3, 4, "1.234");
    run_table("midrst");

`ifdef VGA_TEXT_HOLD_EN
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    hold   = 1'b1;
    wait_done("hold pass");
    add_str(1, 0, "01: 0.000 VH");
    add_str(13, 11, " ");
    run_table("hold");
    set_ch(1, 16'h5555);
    pulse_update();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (busy) n++;
    end
    check("hold no pass", n, 0);
    add_str(1, 4, "0.000");
    run_table("frozen");
    hold = 1'b0;
    pulse_update();
    wait_done("unhold pass");
    add_str(1, 4, "5.555 V ");
    run_table("unhold");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
